// File: rtl/weight_mem_loader_pkg.sv
// Shared widths, FSM state type and address helper for the weight SRAM loader.
package weight_mem_loader_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    // Write address for a beat; wraps modulo 2^ADDR_W by construction.
    function automatic logic [ADDR_W-1:0] wr_address(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/weight_mem_loader_if.sv
// Configuration, weight stream and SRAM write-port bundle of the loader.
interface weight_mem_loader_if;
    import weight_mem_loader_pkg::*;

    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              comp_en;
    logic              busy;
    logic              done;
    logic              wr_cen;
    logic              wr_wen;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_wdata;

    // Controller / stream source / SRAM side.
    modport master (
        output cfg_start, cfg_base, cfg_len, in_valid, in_data, comp_en,
        input  in_ready, busy, done, wr_cen, wr_wen, wr_addr, wr_wdata
    );

    // The loader itself.
    modport slave (
        input  cfg_start, cfg_base, cfg_len, in_valid, in_data, comp_en,
        output in_ready, busy, done, wr_cen, wr_wen, wr_addr, wr_wdata
    );

endinterface

// File: rtl/weight_mem_loader.sv
// Writes a valid/ready stream of weight words into a PE weight SRAM starting at
// a configured base address; compute-side reads (comp_en) always win the port.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   LD_IDLE | waiting for cfg_start; captures base/len on start
//   LD_LOAD | accepting beats, one SRAM write per accepted beat
//   LD_DONE | single-cycle completion pulse, then back to idle
module weight_mem_loader
    import weight_mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    weight_mem_loader_if.slave   bus
);

    ld_state_e         state_q;
    ld_state_e         state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              start;
    logic              accept;
    logic              last_beat;

    assign start     = (state_q == LD_IDLE) && bus.cfg_start;
    assign accept    = bus.in_valid && bus.in_ready;
    assign last_beat = (cnt_q == len_q - ADDR_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero-length start goes straight to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE: begin
                if (bus.cfg_start) begin
                    state_d = (bus.cfg_len != '0) ? LD_LOAD : LD_DONE;
                end
            end
            LD_LOAD: begin
                if (accept && last_beat) begin
                    state_d = LD_DONE;
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    // Load parameters and beat counter; the counter only moves on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            base_q <= bus.cfg_base;
            len_q  <= bus.cfg_len;
            cnt_q  <= '0;
        end else if (accept) begin
            cnt_q  <= cnt_q + ADDR_W'(1);
        end
    end

    // in_ready drops whenever compute reads, so the write port never contends.
    assign bus.in_ready = (state_q == LD_LOAD) && !bus.comp_en;
    assign bus.busy     = (state_q == LD_LOAD);
    assign bus.done     = (state_q == LD_DONE);

    // Zero-latency write strobes; address/data are parked at zero when idle.
    assign bus.wr_cen   = !accept;
    assign bus.wr_wen   = !accept;
    assign bus.wr_addr  = accept ? wr_address(base_q, cnt_q) : '0;
    assign bus.wr_wdata = accept ? bus.in_data : '0;

endmodule
